// File: rtl/ula_acumulador_pkg.sv
// Shared definitions for the accumulator ALU stage: step codes, FSM encoding
// and the operand/result width relationship.
package ula_acumulador_pkg;

    localparam int WIDTH_PADRAO = 4;

    function automatic int largura_resultado(input int largura_operando);
        return 2 * largura_operando;
    endfunction

    localparam int RES_W_PADRAO = largura_resultado(WIDTH_PADRAO);

    localparam logic [3:0] PASSO_LOAD_A = 4'd0;
    localparam logic [3:0] PASSO_LOAD_B = 4'd1;
    localparam logic [3:0] PASSO_SOMA   = 4'd2;
    localparam logic [3:0] PASSO_SUB    = 4'd3;
    localparam logic [3:0] PASSO_MULT   = 4'd4;

    typedef enum logic [1:0] {
        VAZIO = 2'd0,
        TEM_A = 2'd1,
        CHEIO = 2'd2
    } estado_t;

endpackage

// File: rtl/ula_acumulador_comb.sv
// Combinational arithmetic core: sum, difference and product of two unsigned
// operands, widened to the result width.
module ula_comb
    import ula_acumulador_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO,
    parameter int RES_W = largura_resultado(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    output logic [RES_W-1:0] resultado_o,
    output logic             negativo_o
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = {{(RES_W-WIDTH){1'b0}}, a_i};
    assign b_ext = {{(RES_W-WIDTH){1'b0}}, b_i};

    always_comb begin
        resultado_o = '0;
        negativo_o  = 1'b0;
        case (op_i)
            PASSO_SOMA: resultado_o = a_ext + b_ext;
            PASSO_SUB: begin
                // wraps modulo 2^RES_W, giving the two's complement of A-B
                resultado_o = a_ext - b_ext;
                negativo_o  = (a_i < b_i);
            end
            PASSO_MULT: resultado_o = a_ext * b_ext;
            default: begin
                resultado_o = '0;
                negativo_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_acumulador.sv
// Operand-consuming stage after the operand memory: loads A/B, computes on
// request, and flags out-of-order steps for the display logic.
//
// state | meaning
// VAZIO | no operand loaded
// TEM_A | operand A loaded
// CHEIO | operands A and B loaded, compute steps allowed
module ula_acumulador
    import ula_acumulador_pkg::*;
#(
    parameter int WIDTH = WIDTH_PADRAO,
    parameter int RES_W = largura_resultado(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       passo,
    input  logic [WIDTH-1:0] valor,
    input  logic             valido,
    output logic [RES_W-1:0] resultado,
    output logic             negativo,
    output logic             pronto,
    output logic             erro,
    output logic [3:0]       conta_ops
);

    estado_t          estado_q;
    logic [WIDTH-1:0] reg_a_q;
    logic [WIDTH-1:0] reg_b_q;
    logic [RES_W-1:0] resultado_q;
    logic             negativo_q;
    logic             pronto_q;
    logic             erro_q;
    logic [3:0]       conta_q;

    logic [RES_W-1:0] resultado_d;
    logic             negativo_d;

    ula_comb #(
        .WIDTH(WIDTH),
        .RES_W(RES_W)
    ) u_ula_comb (
        .a_i        (reg_a_q),
        .b_i        (reg_b_q),
        .op_i       (passo),
        .resultado_o(resultado_d),
        .negativo_o (negativo_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= VAZIO;
            reg_a_q     <= '0;
            reg_b_q     <= '0;
            resultado_q <= '0;
            negativo_q  <= 1'b0;
            pronto_q    <= 1'b0;
            erro_q      <= 1'b0;
            conta_q     <= '0;
        end else begin
            pronto_q <= 1'b0;
            if (valido) begin
                case (passo)
                    PASSO_LOAD_A: begin
                        reg_a_q  <= valor;
                        estado_q <= TEM_A;
                        erro_q   <= 1'b0;
                    end
                    PASSO_LOAD_B: begin
                        if (estado_q == VAZIO) begin
                            erro_q <= 1'b1;
                        end else begin
                            reg_b_q  <= valor;
                            estado_q <= CHEIO;
                        end
                    end
                    PASSO_SOMA, PASSO_SUB, PASSO_MULT: begin
                        if (estado_q == CHEIO) begin
                            resultado_q <= resultado_d;
                            negativo_q  <= negativo_d;
                            pronto_q    <= 1'b1;
                            conta_q     <= conta_q + 4'd1;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end
                    default: erro_q <= 1'b1;
                endcase
            end
        end
    end

    assign resultado = resultado_q;
    assign negativo  = negativo_q;
    assign pronto    = pronto_q;
    assign erro      = erro_q;
    assign conta_ops = conta_q;

endmodule

// File: tb/tb_ula_acumulador.sv
// Directed bench for ula_acumulador with hand-computed expected values.
module tb_ula_acumulador;

    logic       clock;
    logic       reset;
    logic [3:0] passo;
    logic [3:0] valor;
    logic       valido;
    logic [7:0] resultado;
    logic       negativo;
    logic       pronto;
    logic       erro;
    logic [3:0] conta_ops;

    int erros = 0;
    int total = 0;

    ula_acumulador #(.WIDTH(4), .RES_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .passo    (passo),
        .valor    (valor),
        .valido   (valido),
        .resultado(resultado),
        .negativo (negativo),
        .pronto   (pronto),
        .erro     (erro),
        .conta_ops(conta_ops)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verificar(input string tag, input logic [15:0] obs, input logic [15:0] esp);
        total++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
        end
    endtask

    // one valid step per call; consecutive calls hit consecutive edges
    task automatic aplica(input logic [3:0] p, input logic [3:0] v);
        @(negedge clock);
        passo  = p;
        valor  = v;
        valido = 1'b1;
        @(posedge clock);
        #1;
        valido = 1'b0;
    endtask

    task automatic resetar();
        @(negedge clock);
        reset  = 1'b1;
        valido = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic checa_reset(input string tag);
        verificar({tag, "_res"},   16'(resultado), 16'h00);
        verificar({tag, "_neg"},   16'(negativo),  16'h0);
        verificar({tag, "_pronto"},16'(pronto),    16'h0);
        verificar({tag, "_erro"},  16'(erro),      16'h0);
        verificar({tag, "_conta"}, 16'(conta_ops), 16'h0);
    endtask

    initial begin
        reset  = 1'b1;
        passo  = 4'd0;
        valor  = 4'd0;
        valido = 1'b0;
        resetar();
        checa_reset("rst");

        // basic sequence A=5, B=3
        aplica(4'd0, 4'd5);
        aplica(4'd1, 4'd3);
        aplica(4'd2, 4'd0);
        verificar("soma_res", 16'(resultado), 16'h08);
        verificar("soma_pronto", 16'(pronto), 16'h1);
        verificar("soma_neg", 16'(negativo), 16'h0);
        aplica(4'd3, 4'd0);
        verificar("sub_res", 16'(resultado), 16'h02);
        verificar("sub_pronto", 16'(pronto), 16'h1);
        verificar("sub_neg", 16'(negativo), 16'h0);
        aplica(4'd4, 4'd0);
        verificar("mult_res", 16'(resultado), 16'h0F);
        verificar("mult_pronto", 16'(pronto), 16'h1);
        verificar("mult_neg", 16'(negativo), 16'h0);
        verificar("seq_conta", 16'(conta_ops), 16'h3);
        verificar("seq_erro", 16'(erro), 16'h0);
        @(posedge clock); #1;
        verificar("pronto_cai", 16'(pronto), 16'h0);

        // negative difference A=3, B=5
        aplica(4'd0, 4'd3);
        aplica(4'd1, 4'd5);
        aplica(4'd3, 4'd0);
        verificar("subneg_res", 16'(resultado), 16'hFE);
        verificar("subneg_neg", 16'(negativo), 16'h1);
        aplica(4'd2, 4'd0);
        verificar("soma2_res", 16'(resultado), 16'h08);
        verificar("soma2_neg", 16'(negativo), 16'h0);

        // maximum operands A=15, B=15
        aplica(4'd0, 4'd15);
        aplica(4'd1, 4'd15);
        aplica(4'd4, 4'd0);
        verificar("multmax_res", 16'(resultado), 16'hE1);
        aplica(4'd2, 4'd0);
        verificar("somamax_res", 16'(resultado), 16'h1E);
        verificar("somamax_conta", 16'(conta_ops), 16'h7);

        // B replaced while CHEIO: 15+2
        aplica(4'd1, 4'd2);
        verificar("troca_b_erro", 16'(erro), 16'h0);
        verificar("troca_b_conta", 16'(conta_ops), 16'h7);
        aplica(4'd2, 4'd0);
        verificar("troca_b_res", 16'(resultado), 16'h11);
        verificar("troca_b_cont2", 16'(conta_ops), 16'h8);

        // invalid step in CHEIO
        aplica(4'd7, 4'd0);
        verificar("inval_erro", 16'(erro), 16'h1);
        verificar("inval_res", 16'(resultado), 16'h11);
        verificar("inval_conta", 16'(conta_ops), 16'h8);
        verificar("inval_pronto", 16'(pronto), 16'h0);

        // valido low with a compute code present
        @(negedge clock);
        passo  = 4'd4;
        valido = 1'b0;
        @(posedge clock); #1;
        verificar("ocioso_res", 16'(resultado), 16'h11);
        verificar("ocioso_pronto", 16'(pronto), 16'h0);
        verificar("ocioso_conta", 16'(conta_ops), 16'h8);
        verificar("ocioso_erro", 16'(erro), 16'h1);

        // reset concurrent with a valid compute step in CHEIO
        @(negedge clock);
        reset  = 1'b1;
        passo  = 4'd2;
        valido = 1'b1;
        @(posedge clock); #1;
        valido = 1'b0;
        reset  = 1'b0;
        checa_reset("rst_conc");

        // out-of-order after reset: operands were discarded
        aplica(4'd2, 4'd0);
        verificar("ooo_soma_erro", 16'(erro), 16'h1);
        verificar("ooo_soma_res", 16'(resultado), 16'h00);
        verificar("ooo_soma_pronto", 16'(pronto), 16'h0);
        verificar("ooo_soma_conta", 16'(conta_ops), 16'h0);
        aplica(4'd1, 4'd9);
        verificar("ooo_b_erro", 16'(erro), 16'h1);
        aplica(4'd0, 4'd5);
        verificar("ooo_a_erro", 16'(erro), 16'h0);
        // in TEM_A a compute step must still fault
        aplica(4'd3, 4'd0);
        verificar("tem_a_erro", 16'(erro), 16'h1);
        verificar("tem_a_res", 16'(resultado), 16'h00);
        aplica(4'd0, 4'd5);
        aplica(4'd1, 4'd2);
        aplica(4'd2, 4'd0);
        verificar("ooo_fim_res", 16'(resultado), 16'h07);
        verificar("ooo_fim_conta", 16'(conta_ops), 16'h1);

        // 17 back-to-back compute steps from a fresh reset: A=6, B=2
        resetar();
        aplica(4'd0, 4'd6);
        aplica(4'd1, 4'd2);
        for (int i = 0; i < 17; i++) begin
            aplica(4'(2 + (i % 3)), 4'd0);
            verificar("rajada_pronto", 16'(pronto), 16'h1);
        end
        // last step i=16 -> 16%3=1 -> SUB: 6-2
        verificar("rajada_res", 16'(resultado), 16'h04);
        verificar("rajada_conta", 16'(conta_ops), 16'h1);
        verificar("rajada_erro", 16'(erro), 16'h0);

        $display("Result: errors=%0d of %0d checks", erros, total);
        $finish;
    end

endmodule
